// File: rtl/waveform_playback_ctrl.sv
// waveform_playback_ctrl: sample-table address sequencer with continuous, single and burst playback.
module waveform_playback_ctrl #(
  parameter int ADDR_W      = 15,
  parameter int DEFAULT_END = 32734,
  parameter int BURST_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0]  start_r, end_r, step_r, step_eff;
  logic [BURST_W-1:0] burst_r, burst_eff, pass_cnt;
  logic [1:0]         mode_r;
  logic [ADDR_W:0]    nxt;
  logic               pass_end, last_pass, accept;

  always_comb begin
    step_eff  = step_r == '0 ? ADDR_W'(1) : step_r;
    burst_eff = burst_r == '0 ? BURST_W'(1) : burst_r;
    // one extra bit so a step past the top of the table ends the pass instead of wrapping
    nxt       = {1'b0, rd_addr} + {1'b0, step_eff};
    pass_end  = nxt > {1'b0, end_r};
    last_pass = mode_r == 2'b10 ? (pass_cnt + BURST_W'(1) == burst_eff) : mode_r != 2'b00;
    accept    = state == S_IDLE && start && !stop && start_r <= end_r;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = stop ? S_IDLE : (pass_end && last_pass) ? S_DONE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = state == S_RUN;
    rd_valid = state == S_RUN;
    done     = state == S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_r  <= '0;
      end_r    <= ADDR_W'(DEFAULT_END);
      step_r   <= ADDR_W'(1);
      burst_r  <= BURST_W'(1);
      mode_r   <= '0;
      pass_cnt <= '0;
      rd_addr  <= '0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wrap <= state == S_RUN && !stop && pass_end;
      err  <= state == S_IDLE && start && !stop && start_r > end_r;
      if (cfg_we && state != S_RUN)
        case (cfg_addr)
          2'd0:    start_r <= cfg_data;
          2'd1:    end_r   <= cfg_data;
          2'd2:    step_r  <= cfg_data;
          default: burst_r <= cfg_data[BURST_W-1:0];
        endcase
      if (accept) begin
        rd_addr  <= start_r;
        pass_cnt <= '0;
        mode_r   <= mode;
      end else if (state == S_RUN) begin
        if (stop) pass_cnt <= '0;
        else if (pass_end) begin
          pass_cnt <= pass_cnt + BURST_W'(1);
          if (!last_pass) rd_addr <= start_r;
        end else rd_addr <= nxt[ADDR_W-1:0];
      end
    end
endmodule

// File: tb/tb_waveform_playback_ctrl.sv
// tb_waveform_playback_ctrl: directed and random playback runs checked against an address-list model.
module tb_waveform_playback_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [14:0] cfg_data = '0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [14:0] rd_addr;
  logic        rd_valid, busy, wrap, done, err;
  int          checks = 0;
  int          errors = 0;

  waveform_playback_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .mode(mode), .start(start), .stop(stop), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .busy(busy), .wrap(wrap), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = 15'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  // Expected playback is the list of addresses s, s+step, ... <= e, repeated once per pass.
  task automatic play(input int s, input int e, input int st, input int b, input int md, input int stop_at);
    int q[$];
    bit fp[$];
    int se, np;
    se = st == 0 ? 1 : st;
    np = md == 2 ? (b == 0 ? 1 : b) : 1;
    for (int p = 0; md == 0 ? q.size() < stop_at : p < np; p++)
      for (int a = s; a <= e; a += se) begin
        q.push_back(a);
        fp.push_back(p > 0 && a == s);
      end
    wr(2'd0, s);
    wr(2'd1, e);
    wr(2'd2, st);
    wr(2'd3, b);
    mode = 2'(md);
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      chk("valid", rd_valid, 1);
      chk("addr", rd_addr, q[i]);
      chk("wrap", wrap, fp[i]);
      chk("done", done, 0);
      cfg_we = i == 0;
      cfg_addr = 2'($urandom);
      cfg_data = 15'($urandom);
      stop = i == stop_at - 1;
      start = i == 1 || (stop && $urandom_range(0, 1) == 1);
      tick();
      cfg_we = 1'b0;
      start = 1'b0;
      if (stop) begin
        stop = 1'b0;
        chk("stop_valid", rd_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_wrap", wrap, 0);
        chk("stop_done", done, 0);
        tick();
        chk("post_stop_done", done, 0);
        chk("post_stop_valid", rd_valid, 0);
        return;
      end
    end
    chk("end_done", done, 1);
    chk("end_wrap", wrap, 1);
    chk("end_valid", rd_valid, 0);
    chk("end_busy", busy, 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_valid", rd_valid, 0);
    chk("idle_addr", rd_addr, q[q.size()-1]);
  endtask

  initial begin
    #2;
    chk("rst_addr", rd_addr, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    play(0, 32734, 1, 1, 0, 32735 + 3);
    play(10, 20, 4, 1, 1, 0);
    play(0, 3, 1, 3, 2, 0);
    wr(2'd0, 100);
    wr(2'd1, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", rd_valid, 0);
    tick();
    chk("err_clear", err, 0);
    chk("err_valid2", rd_valid, 0);
    wr(2'd0, 0);
    wr(2'd1, 3);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_valid", rd_valid, 0);
    chk("ss_err", err, 0);
    play(0, 3, 1, 1, 0, 4);
    play(0, 3, 1, 2, 2, 8);
    play(5, 5, 1, 1, 0, 4);
    play(5, 5, 0, 2, 3, 0);
    play(32752, 32767, 32767, 1, 1, 0);
    for (int r = 0; r < 25; r++) begin
      int s, e, st, b, md, se, np, len, sa;
      s = $urandom_range(0, 300);
      e = s + $urandom_range(0, 40);
      st = $urandom_range(0, 6);
      b = $urandom_range(0, 4);
      md = $urandom_range(0, 3);
      se = st == 0 ? 1 : st;
      np = md == 2 ? (b == 0 ? 1 : b) : 1;
      len = ((e - s) / se + 1) * np;
      sa = md == 0 ? $urandom_range(1, 150) : ($urandom_range(0, 1) == 1 ? $urandom_range(1, len) : 0);
      play(s, e, st, b, md, sa);
    end
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", rd_addr, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_lost_a0", rd_addr, 0);
    tick();
    chk("cfg_lost_a1", rd_addr, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cfg_lost_stop", rd_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
